// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one core's memory-bus port among fetch/load/store
// requesters; one outstanding transaction, responses routed back by owner.
module mem_bus_arbiter #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned ADDR_W  = 64,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned ID_W    = 8
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   input  logic [NUM_REQ-1:0]        req_is_write,
   input  logic [NUM_REQ*ID_W-1:0]   req_id,
   output logic                      mem_req_valid,
   input  logic                      mem_req_ready,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   output logic                      mem_is_write,
   output logic [ID_W-1:0]           mem_id,
   input  logic                      mem_rsp_valid,
   input  logic [DATA_W-1:0]         mem_rsp_data,
   input  logic [ID_W-1:0]           mem_rsp_id,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      err_id_mismatch,
   output logic [31:0]               wait_cycles
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_e;

   state_e              state_q, state_d;
   logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]    owner_q, owner_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                is_write_q, is_write_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic                err_q, err_d;
   logic [31:0]         wait_q, wait_d;

   logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
   logic [DATA_W-1:0]   wdata_arr [NUM_REQ];
   logic [ID_W-1:0]     id_arr    [NUM_REQ];

   logic                grant_found;
   logic [PTR_W-1:0]    grant_idx;
   logic [NUM_REQ-1:0]  grant_oh;
   logic                stalled;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
      assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
      assign id_arr[g]    = req_id[g*ID_W +: ID_W];
   end

   // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ.
   always_comb begin : grant_scan
      logic [PTR_W-1:0] idx;
      grant_found = 1'b0;
      grant_idx   = '0;
      grant_oh    = '0;
      idx         = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = PTR_W'((32'(rr_ptr_q) + k) % NUM_REQ);
         if (!grant_found && req_valid[idx]) begin
            grant_found = 1'b1;
            grant_idx   = idx;
         end
      end
      if (grant_found) begin
         grant_oh[grant_idx] = 1'b1;
      end
   end

   // Gated by reset_n so the combinational grant stays quiet while reset is held.
   assign req_ready = (state_q == IDLE && reset_n) ? grant_oh : '0;
   assign stalled   = (|req_valid) & ~(|(req_valid & req_ready));

   always_comb begin : next_state
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      owner_d       = owner_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      is_write_d    = is_write_q;
      id_d          = id_q;
      rsp_valid_d   = '0;
      rsp_data_d    = rsp_data_q;
      err_d         = err_q;
      wait_d        = (stalled && wait_q != '1) ? wait_q + 32'd1 : wait_q;
      mem_req_valid = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (grant_found) begin
               owner_d    = grant_idx;
               addr_d     = addr_arr[grant_idx];
               wdata_d    = wdata_arr[grant_idx];
               is_write_d = req_is_write[grant_idx];
               id_d       = id_arr[grant_idx];
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) begin
               state_d = WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            if (mem_rsp_valid) begin
               if (mem_rsp_id == id_q) begin
                  rsp_valid_d = NUM_REQ'(1) << owner_q;
                  rsp_data_d  = mem_rsp_data;
                  rr_ptr_d    = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                  state_d     = IDLE;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         is_write_q  <= 1'b0;
         id_q        <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         err_q       <= 1'b0;
         wait_q      <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         is_write_q  <= is_write_d;
         id_q        <= id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         err_q       <= err_d;
         wait_q      <= wait_d;
      end
   end

   assign mem_addr        = addr_q;
   assign mem_wdata       = wdata_q;
   assign mem_is_write    = is_write_q;
   assign mem_id          = id_q;
   assign rsp_valid       = rsp_valid_q;
   assign rsp_data        = rsp_data_q;
   assign err_id_mismatch = err_q;
   assign wait_cycles     = wait_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: scenario tasks plus a response scoreboard.
module tb_mem_bus_arbiter;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [2:0]    req_valid;
   logic [2:0]    req_ready;
   logic [191:0]  req_addr;
   logic [191:0]  req_wdata;
   logic [2:0]    req_is_write;
   logic [23:0]   req_id;
   logic          mem_req_valid;
   logic          mem_req_ready;
   logic [63:0]   mem_addr;
   logic [63:0]   mem_wdata;
   logic          mem_is_write;
   logic [7:0]    mem_id;
   logic          mem_rsp_valid;
   logic [63:0]   mem_rsp_data;
   logic [7:0]    mem_rsp_id;
   logic [2:0]    rsp_valid;
   logic [63:0]   rsp_data;
   logic          err_id_mismatch;
   logic [31:0]   wait_cycles;

   logic [63:0]   a_arr [3];
   logic [63:0]   wd_arr [3];
   logic [7:0]    id_arr [3];

   assign req_addr  = {a_arr[2], a_arr[1], a_arr[0]};
   assign req_wdata = {wd_arr[2], wd_arr[1], wd_arr[0]};
   assign req_id    = {id_arr[2], id_arr[1], id_arr[0]};

   typedef struct {
      logic [2:0]  oh;
      logic [63:0] data;
      bit          chk_data;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   mem_bus_arbiter #(.NUM_REQ(3), .ADDR_W(64), .DATA_W(64), .ID_W(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_is_write(req_is_write), .req_id(req_id),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_is_write(mem_is_write),
      .mem_id(mem_id), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .mem_rsp_id(mem_rsp_id), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .err_id_mismatch(err_id_mismatch), .wait_cycles(wait_cycles)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   // Inputs are driven at posedge+1, outputs sampled at posedge+2.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req_valid     = '0;
      req_is_write  = '0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      mem_rsp_id    = '0;
      for (int i = 0; i < 3; i++) begin
         a_arr[i] = '0; wd_arr[i] = '0; id_arr[i] = '0;
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      clear_inputs();
      tick();
      tick();
      reset_n = 1'b1;
      sb.delete();
   endtask

   task automatic pop_exp(output exp_t e);
      if (sb.size() == 0) begin
         e.oh = 3'b111; e.data = '0; e.chk_data = 1'b0;
      end else begin
         e = sb.pop_front();
      end
   endtask

   // Behaves as a memory: waits (bounded) for an offer, accepts, answers next cycle.
   task automatic mem_serve(input logic [7:0] id, input logic [63:0] data, output bit ok);
      int c;
      ok = 1'b0;
      c  = 0;
      while (!ok && c < 20) begin
         if (mem_req_valid === 1'b1) ok = 1'b1;
         else begin tick(); #1; c++; end
      end
      if (ok) begin
         mem_req_ready = 1'b1;
         tick();
         mem_req_ready = 1'b0;
         mem_rsp_valid = 1'b1;
         mem_rsp_id    = id;
         mem_rsp_data  = data;
         tick();
         mem_rsp_valid = 1'b0;
         #1;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      clear_inputs();
      req_valid = 3'b111;
      tick();
      tick();
      #1;
      n_cmp++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL rst_req_ready: got %b exp 000", req_ready); end
      n_cmp++; if ({mem_req_valid, rsp_valid, err_id_mismatch, wait_cycles} !== 37'd0) begin n_bad++; $display("FAIL rst_ctrl: got v=%b rsp=%b err=%b wait=%0d exp all 0", mem_req_valid, rsp_valid, err_id_mismatch, wait_cycles); end
      n_cmp++; if ({mem_addr, mem_wdata, mem_is_write, mem_id} !== 137'd0) begin n_bad++; $display("FAIL rst_latched: got addr=%h wdata=%h wr=%b id=%h exp 0", mem_addr, mem_wdata, mem_is_write, mem_id); end
      req_valid = '0;
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_single_read();
      exp_t e;
      bit   ok;
      a_arr[0] = 64'h40; id_arr[0] = 8'h10;
      req_valid = 3'b001;
      #1;
      n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL rd_ready: got %b exp 001", req_ready); end
      sb.push_back('{oh: 3'b001, data: 64'hDEAD, chk_data: 1'b1});
      tick();
      req_valid = '0;
      #1;
      n_cmp++; if ({mem_req_valid, mem_addr, mem_id, mem_is_write} !== {1'b1, 64'h40, 8'h10, 1'b0}) begin n_bad++; $display("FAIL rd_issue: got v=%b addr=%h id=%h wr=%b exp v=1 addr=40 id=10 wr=0", mem_req_valid, mem_addr, mem_id, mem_is_write); end
      mem_serve(8'h10, 64'hDEAD, ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rd_offer: got %b exp 1", ok); end
      pop_exp(e);
      n_cmp++; if (rsp_valid !== e.oh) begin n_bad++; $display("FAIL rd_rsp_valid: got %b exp %b", rsp_valid, e.oh); end
      n_cmp++; if (rsp_data !== e.data) begin n_bad++; $display("FAIL rd_rsp_data: got %h exp %h", rsp_data, e.data); end
      tick();
      #1;
      n_cmp++; if (rsp_valid !== 3'b000) begin n_bad++; $display("FAIL rd_rsp_pulse: got %b exp 000", rsp_valid); end
      n_cmp++; if (wait_cycles !== 32'd0) begin n_bad++; $display("FAIL rd_wait: got %0d exp 0", wait_cycles); end
   endtask

   task automatic test_round_robin();
      exp_t        e;
      bit          ok;
      int          g;
      logic [2:0]  exp_oh;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         a_arr[i]  = 64'h100 * (i + 1);
         id_arr[i] = 8'h30 + 8'(i);
      end
      req_valid = 3'b111;
      #1;
      for (int k = 0; k < 6; k++) begin
         g      = k % 3;
         exp_oh = 3'b001 << g;
         n_cmp++; if (req_ready !== exp_oh) begin n_bad++; $display("FAIL rr_grant%0d: got %b exp %b", k, req_ready, exp_oh); end
         n_cmp++; if (wait_cycles !== 32'(2 * k)) begin n_bad++; $display("FAIL rr_wait%0d: got %0d exp %0d", k, wait_cycles, 2 * k); end
         sb.push_back('{oh: exp_oh, data: 64'hA000 + 64'(k), chk_data: 1'b1});
         tick();
         #1;
         n_cmp++; if ({req_ready, mem_addr} !== {3'b000, 64'h100 * (g + 1)}) begin n_bad++; $display("FAIL rr_issue%0d: got ready=%b addr=%h exp ready=000 addr=%h", k, req_ready, mem_addr, 64'h100 * (g + 1)); end
         mem_serve(8'h30 + 8'(g), 64'hA000 + 64'(k), ok);
         n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rr_offer%0d: got %b exp 1", k, ok); end
         pop_exp(e);
         n_cmp++; if ({rsp_valid, rsp_data} !== {e.oh, e.data}) begin n_bad++; $display("FAIL rr_rsp%0d: got %b/%h exp %b/%h", k, rsp_valid, rsp_data, e.oh, e.data); end
      end
      req_valid = '0;
      tick();
      #1;
      n_cmp++; if (wait_cycles !== 32'd12) begin n_bad++; $display("FAIL rr_wait_total: got %0d exp 12", wait_cycles); end
   endtask

   task automatic test_issue_stall();
      exp_t e;
      bit   ok;
      a_arr[1] = 64'h200; id_arr[1] = 8'h44;
      req_valid = 3'b010;
      #1;
      n_cmp++; if (req_ready !== 3'b010) begin n_bad++; $display("FAIL st_grant: got %b exp 010", req_ready); end
      sb.push_back('{oh: 3'b010, data: 64'h7777, chk_data: 1'b1});
      tick();
      req_valid = 3'b101;
      a_arr[1]  = 64'hFFFF;
      id_arr[1] = 8'hEE;
      #1;
      for (int c = 0; c < 5; c++) begin
         n_cmp++; if ({mem_req_valid, mem_addr, mem_id, req_ready} !== {1'b1, 64'h200, 8'h44, 3'b000}) begin n_bad++; $display("FAIL st_hold%0d: got v=%b addr=%h id=%h ready=%b exp v=1 addr=200 id=44 ready=000", c, mem_req_valid, mem_addr, mem_id, req_ready); end
         tick();
         #1;
      end
      req_valid = '0;
      mem_serve(8'h44, 64'h7777, ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL st_offer: got %b exp 1", ok); end
      pop_exp(e);
      n_cmp++; if ({rsp_valid, rsp_data} !== {e.oh, e.data}) begin n_bad++; $display("FAIL st_rsp: got %b/%h exp %b/%h", rsp_valid, rsp_data, e.oh, e.data); end
   endtask

   task automatic test_store_write();
      exp_t e;
      bit   ok;
      a_arr[2] = 64'h400; wd_arr[2] = 64'h1234; id_arr[2] = 8'h2C;
      req_is_write = 3'b100;
      req_valid    = 3'b100;
      #1;
      n_cmp++; if (req_ready !== 3'b100) begin n_bad++; $display("FAIL wr_grant: got %b exp 100", req_ready); end
      sb.push_back('{oh: 3'b100, data: 64'h0, chk_data: 1'b0});
      tick();
      req_valid    = '0;
      req_is_write = '0;
      #1;
      n_cmp++; if ({mem_wdata, mem_is_write, mem_addr, mem_id} !== {64'h1234, 1'b1, 64'h400, 8'h2C}) begin n_bad++; $display("FAIL wr_issue: got wdata=%h wr=%b addr=%h id=%h exp 1234/1/400/2c", mem_wdata, mem_is_write, mem_addr, mem_id); end
      mem_serve(8'h2C, 64'h0, ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL wr_offer: got %b exp 1", ok); end
      pop_exp(e);
      n_cmp++; if (rsp_valid !== e.oh) begin n_bad++; $display("FAIL wr_ack: got %b exp %b", rsp_valid, e.oh); end
   endtask

   task automatic test_id_mismatch();
      exp_t e;
      a_arr[1] = 64'h300; id_arr[1] = 8'h21;
      req_valid = 3'b010;
      #1;
      n_cmp++; if (req_ready !== 3'b010) begin n_bad++; $display("FAIL id_grant: got %b exp 010", req_ready); end
      sb.push_back('{oh: 3'b010, data: 64'h5555, chk_data: 1'b1});
      tick();
      req_valid     = '0;
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1; mem_rsp_id = 8'h22; mem_rsp_data = 64'hBAD;
      tick();
      mem_rsp_valid = 1'b0;
      #1;
      n_cmp++; if ({rsp_valid, err_id_mismatch} !== {3'b000, 1'b1}) begin n_bad++; $display("FAIL id_drop: got rsp=%b err=%b exp rsp=000 err=1", rsp_valid, err_id_mismatch); end
      tick();
      #1;
      n_cmp++; if ({rsp_valid, err_id_mismatch} !== {3'b000, 1'b1}) begin n_bad++; $display("FAIL id_sticky: got rsp=%b err=%b exp rsp=000 err=1", rsp_valid, err_id_mismatch); end
      mem_rsp_valid = 1'b1; mem_rsp_id = 8'h21; mem_rsp_data = 64'h5555;
      tick();
      mem_rsp_valid = 1'b0;
      #1;
      pop_exp(e);
      n_cmp++; if ({rsp_valid, rsp_data, err_id_mismatch} !== {e.oh, e.data, 1'b1}) begin n_bad++; $display("FAIL id_deliver: got %b/%h err=%b exp %b/%h err=1", rsp_valid, rsp_data, err_id_mismatch, e.oh, e.data); end
   endtask

   task automatic test_reset_mid();
      a_arr[2] = 64'h500; id_arr[2] = 8'h2D;
      req_valid = 3'b100;
      #1;
      n_cmp++; if (req_ready !== 3'b100) begin n_bad++; $display("FAIL rm_grant: got %b exp 100", req_ready); end
      sb.push_back('{oh: 3'b100, data: 64'hBEEF, chk_data: 1'b1});
      tick();
      req_valid     = '0;
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      #1;
      reset_n = 1'b0;
      #1;
      n_cmp++; if ({req_ready, mem_req_valid, rsp_valid, err_id_mismatch, wait_cycles} !== 40'd0) begin n_bad++; $display("FAIL rm_ctrl: got ready=%b v=%b rsp=%b err=%b wait=%0d exp all 0", req_ready, mem_req_valid, rsp_valid, err_id_mismatch, wait_cycles); end
      n_cmp++; if ({mem_addr, mem_wdata, mem_is_write, mem_id} !== 137'd0) begin n_bad++; $display("FAIL rm_latched: got addr=%h id=%h exp 0", mem_addr, mem_id); end
      tick();
      reset_n = 1'b1;
      sb.delete();
      mem_rsp_valid = 1'b1; mem_rsp_id = 8'h2D; mem_rsp_data = 64'hBEEF;
      tick();
      mem_rsp_valid = 1'b0;
      #1;
      n_cmp++; if ({rsp_valid, err_id_mismatch} !== {3'b000, 1'b0}) begin n_bad++; $display("FAIL rm_stale: got rsp=%b err=%b exp rsp=000 err=0", rsp_valid, err_id_mismatch); end
      req_valid = 3'b111;
      #1;
      n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL rm_rrptr: got %b exp 001", req_ready); end
      req_valid = '0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_issue_stall();
      test_store_write();
      test_id_mismatch();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one core's single memory-bus port among the per-core requesters: fetch, load and store stages.
- Accepts read and write requests from NUM_REQ requesters, grants them round-robin, and issues one transaction at a time to the cache/memory side.
- Routes each response back to the requester that owns it.
- Sits between the pipeline stages and the cache hierarchy, one instance per core.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 = fetch, 1 = load, 2 = store.
- ADDR_W, 64, memory_address_t width.
- DATA_W, 64, payload width.
- ID_W, 8, bus ID width, as produced by createBusID(core_id, component).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request pending.
- req_ready  out  NUM_REQ  one-hot; requester i's request is accepted in the cycle req_valid[i] and req_ready[i] are both 1.
- req_addr  in  NUM_REQ*ADDR_W  request addresses; slice i belongs to requester i.
- req_wdata  in  NUM_REQ*DATA_W  write data.
- req_is_write  in  NUM_REQ  1 = write, 0 = read.
- req_id  in  NUM_REQ*ID_W  bus ID of each requester.
- mem_req_valid  out  1  transaction offered to memory side.
- mem_req_ready  in  1  memory side accepts the transaction.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched write data.
- mem_is_write  out  1  latched direction.
- mem_id  out  ID_W  latched bus ID.
- mem_rsp_valid  in  1  response present (read data or write ack).
- mem_rsp_data  in  DATA_W  response payload.
- mem_rsp_id  in  ID_W  response bus ID.
- rsp_valid  out  NUM_REQ  one-hot, single-cycle response strobe to the owner.
- rsp_data  out  DATA_W  registered payload, broadcast to all requesters.
- err_id_mismatch  out  1  sticky; set on a response whose ID differs from the outstanding ID.
- wait_cycles  out  32  saturating count of cycles with any req_valid high and none granted.

Behaviour:
- Reset, asynchronous while reset_n=0:
  - state=IDLE, rr_ptr=0.
  - All outputs 0, including req_ready, mem_req_valid, rsp_valid, err_id_mismatch and wait_cycles; latched mem_* fields are 0.
- Reset asserted mid-transaction abandons it. No response is delivered after reset; a late mem_rsp_valid arriving in IDLE is ignored and does not set the error flag.
- States: IDLE, ISSUE, WAIT_RSP.
- IDLE:
  - Grant g = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits are 0. req_ready is 0 in every state other than IDLE.
  - On the accept edge: latch addr/wdata/is_write/id of g and owner=g, then go to ISSUE.
  - No req_valid high: stay in IDLE.
- ISSUE:
  - mem_req_valid=1 with the latched fields held stable.
  - On mem_req_valid & mem_req_ready: go to WAIT_RSP.
  - mem_req_ready low: hold, with no timeout.
- WAIT_RSP:
  - mem_req_valid=0.
  - On mem_rsp_valid with mem_rsp_id==latched id: next cycle rsp_valid[owner]=1 for exactly one cycle and rsp_data=mem_rsp_data; rr_ptr=(owner+1) mod NUM_REQ; go to IDLE.
  - On mem_rsp_valid with an ID mismatch: the response is dropped, err_id_mismatch is set to 1 and held until reset, and the state remains WAIT_RSP.
  - mem_rsp_valid observed in IDLE or ISSUE is ignored.
- Writes also wait for a response (ack); rsp_data is then don't-care.
- Latency:
  - Accept at cycle T → mem_req_valid at T+1.
  - Response at cycle R → rsp_valid at R+1, and the state is IDLE in cycle R+1, so a new grant is possible in cycle R+1.
  - Exactly one transaction is outstanding at any time.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,0,… and each requester waits at most NUM_REQ-1 transactions.
- A requester that drops req_valid before its grant is simply skipped.
- req_* inputs are sampled only on the accept edge; later changes do not affect the in-flight transaction.
- wait_cycles increments when (|req_valid) & ~(|(req_valid & req_ready)) and saturates at 32'hFFFFFFFF with no wrap.

Test Plan:
- Reset, then only fetch requests a read of addr 0x40, id 0x10 → req_ready[0] in cycle 0, mem_req_valid with addr 0x40 next cycle; memory acks immediately, rsp id 0x10, data 0xDEAD → rsp_valid=3'b001 for one cycle, rsp_data 0xDEAD.
- All three requesters valid continuously, memory 1-cycle ack → grant order 0,1,2,0,1,2 over six transactions; wait_cycles increments on every non-IDLE cycle.
- Hold mem_req_ready=0 for 5 cycles in ISSUE → mem_addr/mem_id stable, no req_ready asserted, and a transaction is issued on the 6th cycle.
- Response with id 0x22 while 0x21 is outstanding → no rsp_valid, err_id_mismatch=1 and held; a subsequent 0x21 response is delivered normally.
- Store write (is_write=1, wdata 0x1234) → mem_wdata=0x1234, mem_is_write=1; the ack produces rsp_valid=3'b100.
- reset_n pulsed low during WAIT_RSP → outputs 0 immediately; the stale response after reset produces no rsp_valid and no error; rr_ptr=0.
